vdiv_iter_unit: RTL and testbench

VDIV_ITER_UNIT -- requirements
Module: vdiv_iter_unit

---
 rtl/vec_pkg.sv | 25 ++
 rtl/vdiv_core.sv | 88 ++++++++
 rtl/vdiv_iter_unit.sv | 158 +++++++++++++++
 tb/tb_vdiv_iter_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector divide unit: operand-mode encodings,
// sequencer state encoding and a constant-evaluable ceil(log2) helper.
package vec_pkg;

  localparam logic [1:0] CE_VV = 2'b00;
  localparam logic [1:0] CE_VS = 2'b11;
  localparam logic [1:0] CE_SV = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WAIT_IN = 2'd1;
  localparam state_t ST_CALC    = 2'd2;
  localparam state_t ST_OUT     = 2'd3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vdiv_core.sv
// Radix-2 restoring divider on operand magnitudes; signs are re-applied at the
// outputs. The first iteration happens in the start cycle, so a divide takes
// DATA_WIDTH clock edges from start to valid.
module vdiv_core
  import vec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  valid
);

  localparam int CW = clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] q_r, r_r, d_r;
  logic [CW-1:0]         cnt_r;
  logic                  neg_q_r, neg_r_r, busy_r, valid_r;

  logic                  a_neg, b_neg, launch;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, q_cur, r_cur, d_cur, q_nxt, r_nxt;
  logic [DATA_WIDTH:0]   shifted, diff;

  always_comb begin
    a_neg   = is_signed & a[DATA_WIDTH-1];
    b_neg   = is_signed & b[DATA_WIDTH-1];
    mag_a   = a_neg ? -a : a;
    mag_b   = b_neg ? -b : b;
    launch  = start & ~busy_r;
    if (launch) begin
      r_cur = '0;
      q_cur = mag_a;
      d_cur = mag_b;
    end else begin
      r_cur = r_r;
      q_cur = q_r;
      d_cur = d_r;
    end
    shifted = {r_cur, q_cur[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, d_cur};
    // A borrow out of the trial subtraction means this quotient bit is 0.
    r_nxt   = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    q_nxt   = {q_cur[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r     <= '0;
      r_r     <= '0;
      d_r     <= '0;
      cnt_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (launch) begin
      q_r     <= q_nxt;
      r_r     <= r_nxt;
      d_r     <= d_cur;
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
      cnt_r   <= CW'(DATA_WIDTH - 1);
      busy_r  <= 1'b1;
      valid_r <= 1'b0;
    end else if (busy_r) begin
      q_r   <= q_nxt;
      r_r   <= r_nxt;
      cnt_r <= cnt_r - CW'(1);
      if (cnt_r == CW'(1)) begin
        busy_r  <= 1'b0;
        valid_r <= 1'b1;
      end
    end
  end

  assign busy      = busy_r;
  assign valid     = valid_r;
  assign quotient  = neg_q_r ? -q_r : q_r;
  assign remainder = neg_r_r ? -r_r : r_r;

endmodule

// File: rtl/vdiv_iter_unit.sv
// Element sequencer for vector integer divide/remainder: latches the op
// configuration, walks elements through mask/bypass checks and the divider.
//
// state   | meaning
// IDLE    | no op in progress, waiting for start
// WAIT_IN | in_ready high, waiting for the next element
// CALC    | vdiv_core iterating on the accepted element
// OUT     | result presented, waiting for out_ready
module vdiv_iter_unit
  import vec_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  MVL        = 16,
  localparam int VLW        = clog2(MVL) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_rem,
  input  logic                  is_signed,
  input  logic [1:0]            cont_esc,
  input  logic [DATA_WIDTH-1:0] op_esc,
  input  logic                  masked,
  input  logic [MVL-1:0]        mask,
  input  logic [VLW-1:0]        vlr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_mask,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                state_r;
  logic [VLW-1:0]        idx_r, cnt_r;
  logic [MVL-1:0]        mask_r;
  logic                  op_rem_r, signed_r, out_mask_r, done_r;
  logic [1:0]            esc_r;
  logic [DATA_WIDTH-1:0] esc_val_r, out_data_r;

  logic [VLW-1:0]        vlr_eff;
  logic [DATA_WIDTH-1:0] op_a, op_b, core_quo, core_rem;
  logic                  elem_en, div_zero, ovf, accept, core_start, last_elem;
  logic                  core_busy, core_valid;

  always_comb begin
    vlr_eff    = (vlr > VLW'(MVL)) ? VLW'(MVL) : vlr;
    op_a       = (esc_r == CE_SV) ? esc_val_r : in_a;
    op_b       = (esc_r == CE_VS) ? esc_val_r : in_b;
    elem_en    = |(mask_r & (MVL'(1) << idx_r));
    div_zero   = (op_b == '0);
    ovf        = signed_r && (op_a == MIN_VAL) && (op_b == '1);
    accept     = (state_r == ST_WAIT_IN) && in_valid;
    core_start = accept && elem_en && !div_zero && !ovf;
    last_elem  = (idx_r == cnt_r - VLW'(1));
  end

  vdiv_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .a         (op_a),
    .b         (op_b),
    .is_signed (signed_r),
    .busy      (core_busy),
    .quotient  (core_quo),
    .remainder (core_rem),
    .valid     (core_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      cnt_r      <= '0;
      mask_r     <= '0;
      op_rem_r   <= 1'b0;
      signed_r   <= 1'b0;
      esc_r      <= CE_VV;
      esc_val_r  <= '0;
      out_data_r <= '0;
      out_mask_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_rem_r  <= op_rem;
            signed_r  <= is_signed;
            esc_r     <= cont_esc;
            esc_val_r <= op_esc;
            mask_r    <= masked ? mask : '1;
            cnt_r     <= vlr_eff;
            idx_r     <= '0;
            // An empty vector completes immediately without ever going busy.
            if (vlr_eff == '0) done_r <= 1'b1;
            else               state_r <= ST_WAIT_IN;
          end
        end
        ST_WAIT_IN: begin
          if (accept) begin
            if (!elem_en) begin
              out_data_r <= '0;
              out_mask_r <= 1'b0;
              state_r    <= ST_OUT;
            end else if (ovf) begin
              out_data_r <= op_rem_r ? '0 : MIN_VAL;
              out_mask_r <= 1'b1;
              state_r    <= ST_OUT;
            end else if (div_zero) begin
              out_data_r <= op_rem_r ? op_a : '1;
              out_mask_r <= 1'b1;
              state_r    <= ST_OUT;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (core_valid && !core_busy) begin
            out_data_r <= op_rem_r ? core_rem : core_quo;
            out_mask_r <= 1'b1;
            state_r    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            idx_r <= idx_r + VLW'(1);
            if (last_elem) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_WAIT_IN;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == ST_WAIT_IN);
  assign out_valid = (state_r == ST_OUT);
  assign out_last  = (state_r == ST_OUT) && last_elem;
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign out_data  = out_data_r;
  assign out_mask  = out_mask_r;

endmodule

// File: tb/tb_vdiv_iter_unit.sv
// Directed bench for vdiv_iter_unit: hand-computed vectors for unsigned,
// signed, scalar-operand, masked, stall, empty-vector and mid-op reset cases.
module tb_vdiv_iter_unit;

  logic        clk, rst, start, op_rem, is_signed, masked;
  logic [1:0]  cont_esc;
  logic [31:0] op_esc, in_a, in_b, out_data;
  logic [15:0] mask;
  logic [4:0]  vlr;
  logic        in_valid, in_ready, out_valid, out_ready, out_mask, out_last, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  vdiv_iter_unit #(.DATA_WIDTH(32), .MVL(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_rem    (op_rem),
    .is_signed (is_signed),
    .cont_esc  (cont_esc),
    .op_esc    (op_esc),
    .masked    (masked),
    .mask      (mask),
    .vlr       (vlr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_start(input logic rem, input logic sgn, input logic [1:0] esc,
                          input logic [31:0] esc_val, input logic msk,
                          input logic [15:0] m, input logic [4:0] v);
    op_rem = rem; is_signed = sgn; cont_esc = esc; op_esc = esc_val;
    masked = msk; mask = m; vlr = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_elem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                          input logic exp_m, input logic exp_l, input int exp_lat, input int stall);
    int n, lat;
    logic [31:0] held;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_data", out_data, exp_d);
    check("out_mask", 32'(out_mask), 32'(exp_m));
    check("out_last", 32'(out_last), 32'(exp_l));
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, held);
      check("stall_last", 32'(out_last), 32'(exp_l));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_done", 32'(done), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("done", 32'(done), 32'(exp_l));
    check("busy", 32'(busy), 32'(!exp_l));
    if (exp_l) begin
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; start = 1'b0; op_rem = 1'b0; is_signed = 1'b0; cont_esc = 2'b00;
    op_esc = '0; masked = 1'b0; mask = '0; vlr = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // unsigned quotient, VV mode, divide by zero on the last element
    do_start(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 16'h0, 5'd3);
    check("busy_after_start", 32'(busy), 32'd1);
    run_elem(32'd100, 32'd7, 32'd14,         1'b1, 1'b0, 33, 0);
    run_elem(32'd7,   32'd2, 32'd3,          1'b1, 1'b0, 33, 0);
    run_elem(32'd9,   32'd0, 32'hFFFF_FFFF,  1'b1, 1'b1, 1,  0);

    // signed remainder, VS mode with scalar divisor -3
    do_start(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFD, 1'b0, 16'h0, 5'd2);
    run_elem(32'hFFFF_FFF9, 32'd123, 32'hFFFF_FFFF, 1'b1, 1'b0, 33, 0);
    run_elem(32'd7,         32'd123, 32'd1,         1'b1, 1'b1, 33, 0);

    // signed quotient: MIN/-1 overflow bypass, then -7/2
    do_start(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, 16'h0, 5'd2);
    run_elem(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1,  0);
    run_elem(32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b1, 1'b1, 33, 0);

    // masked SV mode: 50 / in_b with mask 0101
    do_start(1'b0, 1'b0, 2'b10, 32'd50, 1'b1, 16'h0005, 5'd4);
    run_elem(32'd0, 32'd5, 32'd10, 1'b1, 1'b0, 33, 0);
    run_elem(32'd0, 32'd5, 32'd0,  1'b0, 1'b0, 1,  0);
    run_elem(32'd0, 32'd5, 32'd10, 1'b1, 1'b0, 33, 0);
    run_elem(32'd0, 32'd5, 32'd0,  1'b0, 1'b1, 1,  0);

    // output back-pressure for 5 cycles
    do_start(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 16'h0, 5'd1);
    run_elem(32'd20, 32'd3, 32'd6, 1'b1, 1'b1, 33, 5);

    // empty vector
    do_start(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 16'h0, 5'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("zero_done_pulse", 32'(done), 32'd0);

    // reset during CALC of element 1
    do_start(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 16'h0, 5'd2);
    run_elem(32'd10, 32'd5, 32'd2, 1'b1, 1'b0, 33, 0);
    in_a = 32'd12; in_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy || done) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    // fresh op; a second start while busy must be ignored
    do_start(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 16'h0, 5'd1);
    do_start(1'b1, 1'b1, 2'b10, 32'd99, 1'b1, 16'h0, 5'd3);
    check("ignored_start_busy", 32'(busy), 32'd1);
    run_elem(32'd9, 32'd4, 32'd2, 1'b1, 1'b1, 33, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
